// File: rtl/memory_array.sv
// rtl/memory_array.sv - parametrised single-port memory with per-bit write mask and init sequencer
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_rw                     1 = write, 0 = read
//   req_addr, req_wdata        entry address and write data
//   req_wmask                  per-bit write enable (1 = bit updated)
//   rsp_valid/rsp_ready        read-response handshake
//   rsp_rdata                  registered read data
//   clear                      re-initialise the whole array to INIT_VAL
//   init_busy                  high while the init sequence is running

module memory_array #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADDR_W   = 3,
    parameter logic [DATA_W-1:0]  INIT_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [DATA_W-1:0] req_wmask,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              clear,
    output logic              init_busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] init_cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic rsp_stall;
    logic req_fire;
    logic wr_fire;
    logic rd_fire;
    logic rsp_taken;

    // An unconsumed response blocks every request so rsp_rdata can hold.
    assign rsp_stall = rsp_valid && !rsp_ready;
    assign rsp_taken = rsp_valid && rsp_ready;
    assign req_fire  = req_valid && req_ready;
    assign wr_fire   = req_fire && req_rw;
    assign rd_fire   = req_fire && !req_rw;

    // State register and init address counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            // Counter only advances while initialising; it sits at zero in
            // IDLE so a clear always restarts the fill from entry 0.
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end else begin
                init_cnt <= '0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT: begin
                // All-ones count is entry DEPTH-1, the last one to fill.
                if (&init_cnt) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear) begin
                    state_nxt = ST_INIT;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        init_busy = 1'b0;
        req_ready = 1'b0;
        case (state)
            ST_INIT: begin
                init_busy = 1'b1;
            end
            ST_IDLE: begin
                // clear takes priority over a same-cycle request.
                req_ready = !clear && !rsp_stall;
            end
            default: begin
                init_busy = 1'b1;
            end
        endcase
    end

    // Read-response register; a response issued before a clear still
    // completes its handshake while the init pass runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (rd_fire) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= mem[req_addr];
            end else if (rsp_taken) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    // Storage: not reset, the init pass overwrites every entry instead.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            mem[init_cnt] <= INIT_VAL;
        end else if (wr_fire) begin
            mem[req_addr] <= (mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        end
    end

endmodule

// File: tb/tb_memory_array.sv
// tb/tb_memory_array.sv - directed scoreboard bench for memory_array

module tb_memory_array;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [DATA_W-1:0] req_wmask;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              clear;
    logic              init_busy;

    memory_array #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .INIT_VAL (8'h00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rw    (req_rw),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .clear     (clear),
        .init_busy (init_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  model [DEPTH];
    logic [7:0]  sb [$];
    logic        last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    endtask

    // One clock: inputs are already driven (at a negedge); look at the
    // handshakes a little later, then move to the next negedge.
    task automatic tick();
        #1;
        last_acc = req_valid && req_ready;
        if (rsp_valid && rsp_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("rsp_data", 32'(rsp_rdata), 32'(sb.pop_front()));
        end
        if (last_acc) begin
            if (req_rw) model[req_addr] = (model[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
            else        sb.push_back(model[req_addr]);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic rw, input logic [2:0] addr, input logic [7:0] wdata, input logic [7:0] wmask);
        int budget;
        req_valid = 1'b1;
        req_rw    = rw;
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        budget    = 50;
        last_acc  = 1'b0;
        while (!last_acc && budget > 0) begin
            tick();
            budget--;
        end
        if (!last_acc) check("req_timeout", 32'd0, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        rsp_ready = 1'b1;
        budget    = 20;
        while (sb.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        check("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic count_init(input string tag, input int exp);
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (init_busy && cnt < 40) begin
            if (req_ready) bad++;
            cnt++;
            tick();
        end
        check({tag, "_cycles"}, 32'(cnt), 32'(exp));
        check({tag, "_ready_low"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_rw    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_wmask = '0;
        rsp_ready = 1'b1;
        clear     = 1'b0;
        model_init();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_init_busy", 32'(init_busy), 32'd1);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        @(negedge clk);

        // 1: read held from reset release; accepted after 8 init cycles
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 3'd0;
        rst_n     = 1'b1;
        count_init("t1_init", DEPTH);
        req(1'b0, 3'd0, 8'h00, 8'h00);
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_rdata", 32'(rsp_rdata), 32'h00);
        drain();

        // 2: write i to addr i, read back in order
        for (int i = 0; i < DEPTH; i++) req(1'b1, 3'(i), 8'(i), 8'hFF);
        for (int i = 0; i < DEPTH; i++) req(1'b0, 3'(i), 8'h00, 8'h00);
        drain();

        // 3: masked write
        req(1'b1, 3'd5, 8'hA5, 8'hFF);
        req(1'b1, 3'd5, 8'h3C, 8'h0F);
        req(1'b0, 3'd5, 8'h00, 8'h00);
        check("t3_masked", 32'(rsp_rdata), 32'hAC);
        drain();

        // 4: backpressure holds the response and blocks the next request
        req(1'b0, 3'd2, 8'h00, 8'h00);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        req_addr  = 3'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_ready_low", 32'(req_ready), 32'd0);
            check("t4_hold_data", 32'(rsp_rdata), 32'h02);
            check("t4_hold_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        req(1'b0, 3'd3, 8'h00, 8'h00);
        check("t4_after", 32'(rsp_rdata), 32'h03);
        drain();

        // 5: back-to-back reads, one per cycle
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_rw    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            req_addr = 3'(i);
            tick();
            check("t5_accept", 32'(last_acc), 32'd1);
            check("t5_valid", 32'(rsp_valid), 32'd1);
        end
        req_valid = 1'b0;
        drain();

        // 6: clear beats a same-cycle write
        clear     = 1'b1;
        req_valid = 1'b1;
        req_rw    = 1'b1;
        req_addr  = 3'd1;
        req_wdata = 8'hFF;
        req_wmask = 8'hFF;
        #1;
        check("t6_ready_clear", 32'(req_ready), 32'd0);
        tick();
        check("t6_not_acc", 32'(last_acc), 32'd0);
        clear     = 1'b0;
        req_valid = 1'b0;
        model_init();
        count_init("t6_init", DEPTH);
        req(1'b0, 3'd1, 8'h00, 8'h00);
        check("t6_rd_addr1", 32'(rsp_rdata), 32'h00);
        drain();

        // 6b: reset pulse partway through init restarts the full count
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t6b_busy_pre", 32'(init_busy), 32'd1);
            tick();
        end
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("t6b_busy_rst", 32'(init_busy), 32'd1);
        tick();
        rst_n = 1'b1;
        model_init();
        count_init("t6b_init", DEPTH);
        req(1'b0, 3'd7, 8'h00, 8'h00);
        check("t6b_rd_addr7", 32'(rsp_rdata), 32'h00);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
